// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared VRAM arbiter widths and owner encodings
package vram_arb_pkg;

  localparam int VRAM_ADDR_W = 16;
  localparam int VRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGEN = 2'd1,
    OWN_HOST = 2'd2,
    OWN_BLIT = 2'd3
  } owner_e;

endpackage

// File: rtl/vram_arb_pick.sv
// rtl/vram_arb_pick.sv - combinational 2-way host/blit picker
// rr_last=0 gives host the tie, rr_last=1 gives blit the tie; held constant 0 for fixed priority.
module vram_arb_pick (
  input  logic elig_host,
  input  logic elig_blit,
  input  logic rr_last,
  output logic grant_host,
  output logic grant_blit
);

  assign grant_host = elig_host && (!elig_blit || !rr_last);
  assign grant_blit = elig_blit && (!elig_host || rr_last);

endmodule

// File: rtl/vram_arb.sv
// rtl/vram_arb.sv - single-port VRAM arbiter: video first, host/blit share blit cycles
// Define VRAM_ARB_RR_EN for round-robin host/blit ties; otherwise host beats blit.
module vram_arb
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              blit_cycle_i,
  input  logic              vgen_sel_i,
  input  logic [ADDR_W-1:0] vgen_addr_i,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_data_i,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_data_o,
  input  logic              blit_req_i,
  input  logic              blit_we_i,
  input  logic [ADDR_W-1:0] blit_addr_i,
  input  logic [DATA_W-1:0] blit_data_i,
  output logic              blit_ack_o,
  output logic [DATA_W-1:0] blit_data_o,
  output logic              vram_sel_o,
  output logic              vram_wr_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic [DATA_W-1:0] vram_data_o,
  input  logic [DATA_W-1:0] vram_data_i
);

  logic              host_infl_q, host_infl_d;
  logic              host_rd_q, host_rd_d;
  logic              host_ack_q, host_ack_d;
  logic [DATA_W-1:0] host_data_q, host_data_d;
  logic              blit_infl_q, blit_infl_d;
  logic              blit_rd_q, blit_rd_d;
  logic              blit_ack_q, blit_ack_d;
  logic [DATA_W-1:0] blit_data_q, blit_data_d;

  logic   free_slot;
  logic   elig_host, elig_blit;
  logic   grant_host, grant_blit;
  logic   rr_last;
  owner_e owner;

  assign free_slot = reset_n_i && blit_cycle_i && !vgen_sel_i;
  assign elig_host = free_slot && host_req_i && !host_infl_q && !host_ack_q;
  assign elig_blit = free_slot && blit_req_i && !blit_infl_q && !blit_ack_q;

  vram_arb_pick u_pick (
    .elig_host  (elig_host),
    .elig_blit  (elig_blit),
    .rr_last    (rr_last),
    .grant_host (grant_host),
    .grant_blit (grant_blit)
  );

`ifdef VRAM_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  // Only contested grants move the pointer; the tie winner loses the next tie.
  always_comb begin
    rr_last_d = rr_last_q;
    if (elig_host && elig_blit) begin
      rr_last_d = grant_host;
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_last_q <= 1'b0;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  assign rr_last = rr_last_q;
`else
  assign rr_last = 1'b0;
`endif

  always_comb begin
    owner = OWN_NONE;
    if (!reset_n_i) begin
      owner = OWN_NONE;
    end else if (vgen_sel_i) begin
      owner = OWN_VGEN;
    end else if (grant_host) begin
      owner = OWN_HOST;
    end else if (grant_blit) begin
      owner = OWN_BLIT;
    end
  end

  always_comb begin
    vram_sel_o  = 1'b0;
    vram_wr_o   = 1'b0;
    vram_addr_o = vgen_addr_i;
    vram_data_o = '0;
    case (owner)
      OWN_VGEN: begin
        vram_sel_o = 1'b1;
      end
      OWN_HOST: begin
        vram_sel_o  = 1'b1;
        vram_wr_o   = host_we_i;
        vram_addr_o = host_addr_i;
        vram_data_o = host_data_i;
      end
      OWN_BLIT: begin
        vram_sel_o  = 1'b1;
        vram_wr_o   = blit_we_i;
        vram_addr_o = blit_addr_i;
        vram_data_o = blit_data_i;
      end
      default: ;
    endcase
  end

  // Writes ack the cycle after issue; reads spend one cycle capturing vram_data_i first.
  always_comb begin
    host_infl_d = host_infl_q;
    host_rd_d   = 1'b0;
    host_ack_d  = 1'b0;
    host_data_d = host_data_q;
    if (host_ack_q) begin
      host_infl_d = 1'b0;
    end
    if (host_rd_q) begin
      host_data_d = vram_data_i;
      host_ack_d  = 1'b1;
    end
    if (grant_host) begin
      host_infl_d = 1'b1;
      host_rd_d   = !host_we_i;
      host_ack_d  = host_we_i;
    end
  end

  always_comb begin
    blit_infl_d = blit_infl_q;
    blit_rd_d   = 1'b0;
    blit_ack_d  = 1'b0;
    blit_data_d = blit_data_q;
    if (blit_ack_q) begin
      blit_infl_d = 1'b0;
    end
    if (blit_rd_q) begin
      blit_data_d = vram_data_i;
      blit_ack_d  = 1'b1;
    end
    if (grant_blit) begin
      blit_infl_d = 1'b1;
      blit_rd_d   = !blit_we_i;
      blit_ack_d  = blit_we_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      host_infl_q <= 1'b0;
      host_rd_q   <= 1'b0;
      host_ack_q  <= 1'b0;
      host_data_q <= '0;
      blit_infl_q <= 1'b0;
      blit_rd_q   <= 1'b0;
      blit_ack_q  <= 1'b0;
      blit_data_q <= '0;
    end else begin
      host_infl_q <= host_infl_d;
      host_rd_q   <= host_rd_d;
      host_ack_q  <= host_ack_d;
      host_data_q <= host_data_d;
      blit_infl_q <= blit_infl_d;
      blit_rd_q   <= blit_rd_d;
      blit_ack_q  <= blit_ack_d;
      blit_data_q <= blit_data_d;
    end
  end

  assign host_ack_o  = host_ack_q;
  assign host_data_o = host_data_q;
  assign blit_ack_o  = blit_ack_q;
  assign blit_data_o = blit_data_q;

`ifndef SYNTHESIS
  // video_gen must never fetch in a cycle it has also handed to host/blit
  vgen_blit_overlap_a : assert property (@(posedge clk) disable iff (!reset_n_i)
    !(vgen_sel_i && blit_cycle_i));
`endif

endmodule

// File: tb/tb_vram_arb.sv
// tb/tb_vram_arb.sv - table-driven bench for vram_arb plus reset, streaming and tie sequences
module tb_vram_arb;

  logic        clk;
  logic        reset_n_i;
  logic        blit_cycle_i;
  logic        vgen_sel_i;
  logic [15:0] vgen_addr_i;
  logic        host_req_i;
  logic        host_we_i;
  logic [15:0] host_addr_i;
  logic [15:0] host_data_i;
  logic        host_ack_o;
  logic [15:0] host_data_o;
  logic        blit_req_i;
  logic        blit_we_i;
  logic [15:0] blit_addr_i;
  logic [15:0] blit_data_i;
  logic        blit_ack_o;
  logic [15:0] blit_data_o;
  logic        vram_sel_o;
  logic        vram_wr_o;
  logic [15:0] vram_addr_o;
  logic [15:0] vram_data_o;
  logic [15:0] vram_data_i;

  int n_cmp;
  int n_fail;

  vram_arb dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .blit_cycle_i (blit_cycle_i),
    .vgen_sel_i   (vgen_sel_i),
    .vgen_addr_i  (vgen_addr_i),
    .host_req_i   (host_req_i),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_data_i  (host_data_i),
    .host_ack_o   (host_ack_o),
    .host_data_o  (host_data_o),
    .blit_req_i   (blit_req_i),
    .blit_we_i    (blit_we_i),
    .blit_addr_i  (blit_addr_i),
    .blit_data_i  (blit_data_i),
    .blit_ack_o   (blit_ack_o),
    .blit_data_o  (blit_data_o),
    .vram_sel_o   (vram_sel_o),
    .vram_wr_o    (vram_wr_o),
    .vram_addr_o  (vram_addr_o),
    .vram_data_o  (vram_data_o),
    .vram_data_i  (vram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        bc;
    logic        vs;
    logic [15:0] vaddr;
    logic        hreq;
    logic        hwe;
    logic [15:0] haddr;
    logic [15:0] hdata;
    logic        breq;
    logic        bwe;
    logic [15:0] baddr;
    logic [15:0] bdata;
    logic [15:0] rdata;
    logic        e_sel;
    logic        e_wr;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_hack;
    logic        e_back;
    logic [15:0] e_hdata;
    logic [15:0] e_bdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic bc, input logic vs, input logic [15:0] vaddr,
                       input logic hreq, input logic hwe, input logic [15:0] haddr, input logic [15:0] hdata,
                       input logic breq, input logic bwe, input logic [15:0] baddr, input logic [15:0] bdata);
    blit_cycle_i = bc;
    vgen_sel_i   = vs;
    vgen_addr_i  = vaddr;
    host_req_i   = hreq;
    host_we_i    = hwe;
    host_addr_i  = haddr;
    host_data_i  = hdata;
    blit_req_i   = breq;
    blit_we_i    = bwe;
    blit_addr_i  = baddr;
    blit_data_i  = bdata;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    //           bc vs vaddr     hreq we haddr     hdata     breq we baddr     bdata     rdata    | sel wr addr      wdata     hack back hdata  bdata
    vecs[0]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000};
    vecs[1]  = '{1, 0, 16'h0000, 1, 1, 16'h0040, 16'h1234, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0040, 16'h1234, 0, 0, 16'h0000, 16'h0000};
    vecs[2]  = '{1, 0, 16'h0000, 1, 1, 16'h0040, 16'h1234, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000};
    vecs[3]  = '{1, 0, 16'h0000, 1, 1, 16'h0040, 16'h1234, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0040, 16'h1234, 0, 0, 16'h0000, 16'h0000};
    vecs[4]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000};
    vecs[5]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0040, 16'h0000, 16'h0000, 1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000};
    vecs[6]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0040, 16'h0000, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000};
    vecs[7]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0040, 16'h0000, 16'hdead, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h1234};
    vecs[8]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hbeef, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h1234};
    vecs[9]  = '{0, 1, 16'h1357, 1, 1, 16'h0100, 16'haaaa, 1, 1, 16'h0200, 16'hbbbb, 16'h0000, 1, 0, 16'h1357, 16'h0000, 0, 0, 16'h0000, 16'h1234};
    vecs[10] = '{0, 0, 16'h2468, 1, 1, 16'h0100, 16'haaaa, 1, 1, 16'h0200, 16'hbbbb, 16'h0000, 0, 0, 16'h2468, 16'h0000, 0, 0, 16'h0000, 16'h1234};
    vecs[11] = '{1, 0, 16'h0000, 1, 1, 16'h0100, 16'haaaa, 1, 1, 16'h0200, 16'hbbbb, 16'h0000, 1, 1, 16'h0100, 16'haaaa, 0, 0, 16'h0000, 16'h1234};
    vecs[12] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0200, 16'hbbbb, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h1234};
    vecs[13] = '{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0200, 16'hbbbb, 16'h0000, 1, 1, 16'h0200, 16'hbbbb, 0, 0, 16'h0000, 16'h1234};
    vecs[14] = '{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h1234};

    reset_n_i   = 1'b0;
    vram_data_i = 16'h0000;
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #1 reset_n_i = 1'b1;
    @(negedge clk);
    check("reset host_ack", {15'd0, host_ack_o}, 16'd0);
    check("reset blit_ack", {15'd0, blit_ack_o}, 16'd0);
    check("reset host_data", host_data_o, 16'h0000);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].bc, vecs[i].vs, vecs[i].vaddr, vecs[i].hreq, vecs[i].hwe, vecs[i].haddr, vecs[i].hdata,
            vecs[i].breq, vecs[i].bwe, vecs[i].baddr, vecs[i].bdata);
      vram_data_i = vecs[i].rdata;
      @(negedge clk);
      check($sformatf("v%0d vram_sel", i), {15'd0, vram_sel_o}, {15'd0, vecs[i].e_sel});
      check($sformatf("v%0d vram_wr", i), {15'd0, vram_wr_o}, {15'd0, vecs[i].e_wr});
      check($sformatf("v%0d vram_addr", i), vram_addr_o, vecs[i].e_addr);
      check($sformatf("v%0d vram_wdata", i), vram_data_o, vecs[i].e_wdata);
      check($sformatf("v%0d host_ack", i), {15'd0, host_ack_o}, {15'd0, vecs[i].e_hack});
      check($sformatf("v%0d blit_ack", i), {15'd0, blit_ack_o}, {15'd0, vecs[i].e_back});
      check($sformatf("v%0d host_data", i), host_data_o, vecs[i].e_hdata);
      check($sformatf("v%0d blit_data", i), blit_data_o, vecs[i].e_bdata);
    end

    // reset asserted while a host read is in flight
    @(posedge clk);
    #1;
    drive(1, 0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    vram_data_i = 16'h5555;
    @(negedge clk);
    check("rst issue sel", {15'd0, vram_sel_o}, 16'd1);
    check("rst issue wr", {15'd0, vram_wr_o}, 16'd0);
    @(posedge clk);
    #1;
    drive(0, 1, 16'h0abc, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    reset_n_i = 1'b0;
    #1;
    check("rst host_ack", {15'd0, host_ack_o}, 16'd0);
    check("rst blit_data", blit_data_o, 16'h0000);
    check("rst host_data", host_data_o, 16'h0000);
    check("rst vram_sel", {15'd0, vram_sel_o}, 16'd0);
    @(posedge clk);
    #1;
    reset_n_i  = 1'b1;
    vgen_sel_i = 1'b0;
    blit_cycle_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post-rst%0d host_ack", k), {15'd0, host_ack_o}, 16'd0);
      check($sformatf("post-rst%0d vram_sel", k), {15'd0, vram_sel_o}, 16'd0);
      check($sformatf("post-rst%0d host_data", k), host_data_o, 16'h0000);
      @(posedge clk);
      #1;
    end

    // both stream writes: after the first tie grants alternate host, blit
    drive(1, 0, 16'h0000, 1, 1, 16'h0300, 16'h1111, 1, 1, 16'h0400, 16'h2222);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("stream%0d sel", k), {15'd0, vram_sel_o}, 16'd1);
      check($sformatf("stream%0d addr", k), vram_addr_o, (k % 2 == 0) ? 16'h0300 : 16'h0400);
      check($sformatf("stream%0d host_ack", k), {15'd0, host_ack_o}, (k % 2 == 1) ? 16'd1 : 16'd0);
      check($sformatf("stream%0d blit_ack", k), {15'd0, blit_ack_o}, (k > 0 && k % 2 == 0) ? 16'd1 : 16'd0);
      @(posedge clk);
      #1;
    end
    drive(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("stream end blit_ack", {15'd0, blit_ack_o}, 16'd1);
    check("stream end sel", {15'd0, vram_sel_o}, 16'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle host_ack", {15'd0, host_ack_o}, 16'd0);
    check("idle blit_ack", {15'd0, blit_ack_o}, 16'd0);

    // a fresh tie after the host won the last contested grant
    @(posedge clk);
    #1;
    drive(1, 0, 16'h0000, 1, 1, 16'h0300, 16'h3333, 1, 1, 16'h0400, 16'h4444);
    @(negedge clk);
`ifdef VRAM_ARB_RR_EN
    check("tie winner addr", vram_addr_o, 16'h0400);
`else
    check("tie winner addr", vram_addr_o, 16'h0300);
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
`ifdef VRAM_ARB_RR_EN
    check("tie loser addr", vram_addr_o, 16'h0300);
    check("tie loser wdata", vram_data_o, 16'h3333);
`else
    check("tie loser addr", vram_addr_o, 16'h0400);
    check("tie loser wdata", vram_data_o, 16'h4444);
`endif
    @(posedge clk);
    #1;
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
